// File: rtl/mssb_tx_arb.sv
// mssb_tx_arb: round-robin arbiter granting one of three byte requesters the
// shared UART transmitter for a whole packet (until the owner's LAST byte is
// accepted).
// Build option: define MSSB_ARB_TIMEOUT_EN to compile in a stall watchdog that
// revokes a grant whose owner withholds its strobe for TIMEOUT_CYCLES cycles.
module mssb_tx_arb #(
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
   input  logic       OPB_CLK,
   input  logic       OPB_RST,
   input  logic [7:0] REQ0_DATA,
   input  logic       REQ0_STB,
   input  logic       REQ0_LAST,
   output logic       REQ0_ACK,
   input  logic [7:0] REQ1_DATA,
   input  logic       REQ1_STB,
   input  logic       REQ1_LAST,
   output logic       REQ1_ACK,
   input  logic [7:0] REQ2_DATA,
   input  logic       REQ2_STB,
   input  logic       REQ2_LAST,
   output logic       REQ2_ACK,
   output logic [7:0] UART_DATA,
   output logic       UART_STB,
   input  logic       UART_ACK,
   input  logic       ERR_CLR,
   output logic [1:0] GRANT,
   output logic       BUSY,
   output logic       TIMEOUT_ERR
);

   typedef enum logic {StIdle = 1'b0, StXfer = 1'b1} state_e;

   state_e     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] ptr_q, ptr_d;
   logic [2:0] stb_vec;
   logic [1:0] pick;
   logic       own_stb, own_last;
   logic [7:0] own_data;
   logic       xfer, acc, timeout;

   // Next index modulo 3; keeps the pointer out of the unused value 3.
   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign stb_vec = {REQ2_STB, REQ1_STB, REQ0_STB};
   assign xfer    = (state_q == StXfer);

   // First requester with STB high, searching upward from the pointer.
   always_comb begin
      pick = 2'd0;
      case (ptr_q)
         2'd1:    pick = stb_vec[1] ? 2'd1 : (stb_vec[2] ? 2'd2 : 2'd0);
         2'd2:    pick = stb_vec[2] ? 2'd2 : (stb_vec[0] ? 2'd0 : 2'd1);
         default: pick = stb_vec[0] ? 2'd0 : (stb_vec[1] ? 2'd1 : 2'd2);
      endcase
   end

   // Select the current owner's byte, strobe and last flag.
   always_comb begin
      own_stb  = 1'b0;
      own_last = 1'b0;
      own_data = 8'h00;
      case (owner_q)
         2'd0:    begin own_stb = REQ0_STB; own_last = REQ0_LAST; own_data = REQ0_DATA; end
         2'd1:    begin own_stb = REQ1_STB; own_last = REQ1_LAST; own_data = REQ1_DATA; end
         2'd2:    begin own_stb = REQ2_STB; own_last = REQ2_LAST; own_data = REQ2_DATA; end
         default: ;
      endcase
   end

   // UART side and acknowledge routing; an ACK without a strobe is ignored.
   always_comb begin
      UART_STB  = xfer & own_stb;
      UART_DATA = xfer ? own_data : 8'h00;
      acc       = UART_STB & UART_ACK;
      REQ0_ACK  = acc & (owner_q == 2'd0);
      REQ1_ACK  = acc & (owner_q == 2'd1);
      REQ2_ACK  = acc & (owner_q == 2'd2);
      GRANT     = xfer ? owner_q : 2'b11;
      BUSY      = xfer;
   end

   // Grant FSM next state: hold the grant until LAST is accepted or a stall times out.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         StIdle: begin
            if (|stb_vec) begin
               state_d = StXfer;
               owner_d = pick;
            end
         end
         StXfer: begin
            if ((acc && own_last) || timeout) begin
               state_d = StIdle;
               ptr_d   = inc3(owner_q);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Grant FSM state, owner and round-robin pointer.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         state_q <= StIdle;
         owner_q <= 2'd0;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef MSSB_ARB_TIMEOUT_EN
   logic [19:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   // Stall counter: counts granted cycles with the owner's strobe low.
   always_comb begin
      cnt_d   = cnt_q;
      timeout = 1'b0;
      if (!xfer || acc) begin
         cnt_d = 20'd0;
      end else if (!own_stb) begin
         if (cnt_q + 20'd1 == TIMEOUT_CYCLES) begin
            timeout = 1'b1;
            cnt_d   = 20'd0;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
      // A timeout in the same cycle as ERR_CLR wins.
      err_d = timeout ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
   end

   // Stall counter and sticky error flag.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         cnt_q <= 20'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign TIMEOUT_ERR = err_q;
`else
   logic unused_err_clr;

   assign timeout        = 1'b0;
   assign TIMEOUT_ERR    = 1'b0;
   assign unused_err_clr = ERR_CLR;
`endif

endmodule

// File: tb/tb_mssb_tx_arb.sv
// Self-checking bench for mssb_tx_arb: requester queues feed bytes, a UART
// model acknowledges them, and a scoreboard of {grant, data} checks order.
module tb_mssb_tx_arb;

   logic       OPB_CLK = 1'b0;
   logic       OPB_RST = 1'b1;
   logic [7:0] REQ0_DATA = '0, REQ1_DATA = '0, REQ2_DATA = '0;
   logic       REQ0_STB = 0, REQ1_STB = 0, REQ2_STB = 0;
   logic       REQ0_LAST = 0, REQ1_LAST = 0, REQ2_LAST = 0;
   logic       REQ0_ACK, REQ1_ACK, REQ2_ACK;
   logic [7:0] UART_DATA;
   logic       UART_STB;
   logic       UART_ACK = 1'b0;
   logic       ERR_CLR = 1'b0;
   logic [1:0] GRANT;
   logic       BUSY;
   logic       TIMEOUT_ERR;

   mssb_tx_arb #(.TIMEOUT_CYCLES(20'd16)) dut (
      .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST),
      .REQ0_DATA(REQ0_DATA), .REQ0_STB(REQ0_STB), .REQ0_LAST(REQ0_LAST), .REQ0_ACK(REQ0_ACK),
      .REQ1_DATA(REQ1_DATA), .REQ1_STB(REQ1_STB), .REQ1_LAST(REQ1_LAST), .REQ1_ACK(REQ1_ACK),
      .REQ2_DATA(REQ2_DATA), .REQ2_STB(REQ2_STB), .REQ2_LAST(REQ2_LAST), .REQ2_ACK(REQ2_ACK),
      .UART_DATA(UART_DATA), .UART_STB(UART_STB), .UART_ACK(UART_ACK),
      .ERR_CLR(ERR_CLR), .GRANT(GRANT), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 OPB_CLK = ~OPB_CLK;

   logic [8:0] rq0[$], rq1[$], rq2[$];   // {last, data} per requester
   logic [9:0] sb[$];                    // expected {grant, data} in UART order
   logic [2:0] en = 3'b111;
   int vectors = 0, miscompares = 0;
   int gap = 1, uart_wait = 0;
   bit expect_idle = 0, expect_grant = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive_reqs();
      REQ0_STB  = en[0] && rq0.size() != 0;
      REQ0_DATA = rq0.size() != 0 ? rq0[0][7:0] : 8'h00;
      REQ0_LAST = rq0.size() != 0 && rq0[0][8];
      REQ1_STB  = en[1] && rq1.size() != 0;
      REQ1_DATA = rq1.size() != 0 ? rq1[0][7:0] : 8'h00;
      REQ1_LAST = rq1.size() != 0 && rq1[0][8];
      REQ2_STB  = en[2] && rq2.size() != 0;
      REQ2_DATA = rq2.size() != 0 ? rq2[0][7:0] : 8'h00;
      REQ2_LAST = rq2.size() != 0 && rq2[0][8];
   endtask

   task automatic load(input int k, input logic [7:0] d, input bit last, input bit to_sb);
      case (k)
         0: rq0.push_back({last, d});
         1: rq1.push_back({last, d});
         default: rq2.push_back({last, d});
      endcase
      if (to_sb) sb.push_back({k[1:0], d});
      drive_reqs();
   endtask

   task automatic pop_req(input logic [1:0] k, output logic [8:0] r);
      r = '0;
      case (k)
         2'd0: if (rq0.size() != 0) r = rq0.pop_front();
         2'd1: if (rq1.size() != 0) r = rq1.pop_front();
         2'd2: if (rq2.size() != 0) r = rq2.pop_front();
         default: ;
      endcase
   endtask

   // One clock: state checks at negedge, UART model ack, then inputs after posedge.
   task automatic cycle();
      logic [9:0] e;
      logic [8:0] r;
      @(negedge OPB_CLK);
      if (expect_grant) begin
         check("arb_latency_busy", BUSY, 1);
         expect_grant = 0;
      end
      if (expect_idle) begin
         check("gap_grant", GRANT, 2'b11);
         check("gap_busy", BUSY, 0);
         check("gap_uart_stb", UART_STB, 0);
         check("gap_uart_data", UART_DATA, 0);
         expect_idle  = 0;
         expect_grant = REQ0_STB | REQ1_STB | REQ2_STB;
      end
      if (UART_STB === 1'b1) begin
         uart_wait++;
         if (uart_wait >= gap) begin
            UART_ACK  = 1'b1;
            uart_wait = 0;
         end
      end else begin
         uart_wait = 0;
      end
      #1;
      if (UART_ACK) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("grant", GRANT, e[9:8]);
            check("uart_data", UART_DATA, e[7:0]);
            check("ack_vec", {REQ2_ACK, REQ1_ACK, REQ0_ACK}, 32'd1 << e[9:8]);
            pop_req(e[9:8], r);
            if (r[8]) expect_idle = 1;
         end
      end else begin
         check("ack_quiet", {REQ2_ACK, REQ1_ACK, REQ0_ACK}, 0);
      end
      @(posedge OPB_CLK);
      #1;
      UART_ACK = 1'b0;
      drive_reqs();
   endtask

   task automatic run_until(input int rem, input int budget);
      int i = 0;
      while ((sb.size() > rem || expect_idle || expect_grant) && i < budget) begin
         cycle();
         i++;
      end
      check("drain_budget", sb.size(), rem);
   endtask

   // Reset at a negedge, optionally with UART_ACK forced high, and check outputs at once.
   task automatic apply_reset(input bit force_ack);
      @(negedge OPB_CLK);
      OPB_RST  = 1'b1;
      UART_ACK = force_ack;
      #1;
      check("rst_grant", GRANT, 2'b11);
      check("rst_busy", BUSY, 0);
      check("rst_uart_stb", UART_STB, 0);
      check("rst_uart_data", UART_DATA, 0);
      check("rst_ack_vec", {REQ2_ACK, REQ1_ACK, REQ0_ACK}, 0);
      check("rst_timeout_err", TIMEOUT_ERR, 0);
      @(posedge OPB_CLK);
      #1;
      UART_ACK = 1'b0;
      @(negedge OPB_CLK);
      OPB_RST = 1'b0;
      sb.delete();
      uart_wait    = 0;
      expect_idle  = 0;
      expect_grant = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      drive_reqs();
      // Reset state
      apply_reset(1'b0);

      // Three-byte packet from requester 0, UART acks every 10 cycles
      gap = 10;
      load(0, 8'h10, 0, 1);
      load(0, 8'h11, 0, 1);
      load(0, 8'h12, 1, 1);
      run_until(0, 200);

      // Pointer now 1: requester 1 wins over 0 when both request together
      gap = 1;
      load(0, 8'h20, 1, 0);
      load(1, 8'h30, 1, 1);
      sb.push_back({2'd0, 8'h20});
      run_until(0, 50);

      // All three request from reset: order 0,1,2,0 with idle gaps
      apply_reset(1'b0);
      load(0, 8'hA0, 0, 0); load(0, 8'hA1, 1, 0); load(0, 8'hA2, 0, 0); load(0, 8'hA3, 1, 0);
      load(1, 8'hB0, 0, 0); load(1, 8'hB1, 1, 0);
      load(2, 8'hC0, 0, 0); load(2, 8'hC1, 1, 0);
      sb.push_back({2'd0, 8'hA0}); sb.push_back({2'd0, 8'hA1});
      sb.push_back({2'd1, 8'hB0}); sb.push_back({2'd1, 8'hB1});
      sb.push_back({2'd2, 8'hC0}); sb.push_back({2'd2, 8'hC1});
      sb.push_back({2'd0, 8'hA2}); sb.push_back({2'd0, 8'hA3});
      run_until(0, 100);

      // Requester 1 arrives mid-packet of requester 0 and must wait
      gap = 3;
      load(0, 8'hD0, 0, 1); load(0, 8'hD1, 0, 1); load(0, 8'hD2, 1, 1);
      repeat (3) cycle();
      load(1, 8'hE0, 1, 1);
      run_until(0, 100);

      // UART_ACK with no strobe: ignored in idle and while the owner stalls
      @(negedge OPB_CLK);
      UART_ACK = 1'b1;
      #1;
      check("idle_ack_vec", {REQ2_ACK, REQ1_ACK, REQ0_ACK}, 0);
      check("idle_ack_stb", UART_STB, 0);
      @(posedge OPB_CLK);
      #1;
      UART_ACK = 1'b0;
      @(negedge OPB_CLK);
      check("idle_ack_grant", GRANT, 2'b11);
      gap = 1;
      load(0, 8'h70, 0, 1); load(0, 8'h71, 1, 1);
      run_until(1, 50);
      en[0] = 1'b0;
      drive_reqs();
      for (int i = 0; i < 5; i++) begin
         @(negedge OPB_CLK);
         UART_ACK = 1'b1;
         #1;
         check("stall_ack_vec", {REQ2_ACK, REQ1_ACK, REQ0_ACK}, 0);
         check("stall_grant", GRANT, 2'd0);
         @(posedge OPB_CLK);
         #1;
         UART_ACK = 1'b0;
      end
      en[0] = 1'b1;
      drive_reqs();
      run_until(0, 50);

      // Reset mid-packet of requester 1; arbitration restarts from pointer 0
      gap = 2;
      load(1, 8'h40, 0, 1); load(1, 8'h41, 0, 1); load(1, 8'h42, 1, 1);
      run_until(2, 50);
      check("pre_reset_grant", GRANT, 2'd1);
      load(0, 8'h50, 1, 0);
      load(2, 8'h60, 1, 0);
      apply_reset(1'b1);
      sb.push_back({2'd0, 8'h50});
      sb.push_back({2'd1, 8'h41}); sb.push_back({2'd1, 8'h42});
      sb.push_back({2'd2, 8'h60});
      run_until(0, 100);

`ifdef MSSB_ARB_TIMEOUT_EN
      // Requester 2 stalls after one byte: release after 16 cycles, sticky error
      gap = 1;
      load(2, 8'h80, 0, 1); load(2, 8'h81, 1, 0);
      run_until(0, 50);
      en[2] = 1'b0;
      drive_reqs();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge OPB_CLK);
         if (GRANT !== 2'd2) break;
         n++;
      end
      check("timeout_cycles", n, 16);
      check("timeout_grant", GRANT, 2'b11);
      check("timeout_err_set", TIMEOUT_ERR, 1);
      rq2.delete();
      en[2] = 1'b1;
      drive_reqs();
      repeat (3) @(negedge OPB_CLK);
      check("timeout_err_sticky", TIMEOUT_ERR, 1);
      ERR_CLR = 1'b1;
      @(posedge OPB_CLK);
      #1;
      ERR_CLR = 1'b0;
      @(negedge OPB_CLK);
      check("timeout_err_cleared", TIMEOUT_ERR, 0);

      // Timeout coinciding with ERR_CLR leaves the flag set
      load(2, 8'h82, 0, 1); load(2, 8'h83, 1, 0);
      run_until(0, 50);
      en[2] = 1'b0;
      ERR_CLR = 1'b1;
      drive_reqs();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge OPB_CLK);
         if (GRANT !== 2'd2) break;
         n++;
      end
      check("timeout2_cycles", n, 16);
      check("timeout_vs_clr", TIMEOUT_ERR, 1);
      ERR_CLR = 1'b0;
      rq2.delete();
      en[2] = 1'b1;
      drive_reqs();
      @(negedge OPB_CLK);
      check("timeout2_sticky", TIMEOUT_ERR, 1);
`else
      // Without the watchdog a stalled grant is never revoked
      gap = 1;
      load(2, 8'h90, 0, 1); load(2, 8'h91, 1, 1);
      run_until(1, 50);
      en[2] = 1'b0;
      ERR_CLR = 1'b1;
      drive_reqs();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge OPB_CLK);
         if (GRANT !== 2'd2) break;
         n++;
      end
      check("no_timeout_hold", n, 40);
      check("no_timeout_err", TIMEOUT_ERR, 0);
      ERR_CLR = 1'b0;
      en[2] = 1'b1;
      drive_reqs();
      run_until(0, 50);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mssb_tx_arb.md
MSSB_TX_ARB -- requirements
Module: mssb_tx_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd100000, SHALL set the stall limit in OPB_CLK cycles (1 ms at 100 MHz).
REQ-002 OPB_CLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 OPB_RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 REQn_DATA  in  8  (n=0..2) SHALL carry requester n's byte.
REQ-005 REQn_STB  in  1  SHALL be requester n's byte-valid strobe, held with stable data until REQn_ACK.
REQ-006 REQn_LAST  in  1  SHALL mark requester n's current byte as the final byte of its packet.
REQ-007 REQn_ACK  out  1  SHALL be the byte-accepted pulse returned to requester n.
REQ-008 UART_DATA  out  8  SHALL drive the shared UART transmitter byte input.
REQ-009 UART_STB  out  1  SHALL drive the UART transmitter byte strobe.
REQ-010 UART_ACK  in  1  SHALL be the UART transmitter byte-accepted pulse.
REQ-011 ERR_CLR  in  1  SHALL synchronously clear TIMEOUT_ERR.
REQ-012 GRANT  out  2  SHALL give the granted requester index, or 2'b11 when none.
REQ-013 BUSY  out  1  SHALL be high while a packet is granted.
REQ-014 TIMEOUT_ERR  out  1  SHALL be a sticky stall flag.

Function
REQ-015 The FSM SHALL have two states: ST_IDLE (GRANT=3, BUSY=0) and ST_XFER (GRANT=owner, BUSY=1).
REQ-016 In ST_IDLE with any REQn_STB high, the FSM SHALL go to ST_XFER next cycle, granting the first requester with STB high, searching from the round-robin pointer PTR upward modulo 3.
REQ-017 In ST_XFER, UART_DATA/UART_STB SHALL be combinationally muxed from the owner; REQn_ACK SHALL equal UART_ACK AND (GRANT==n).
REQ-018 In ST_IDLE, UART_STB SHALL be 0, UART_DATA SHALL be 8'h00, and all REQn_ACK SHALL be 0.
REQ-019 The grant SHALL be held for the whole packet; other requesters' STB SHALL be ignored until release.
REQ-020 On UART_ACK with owner LAST=1, the FSM SHALL return to ST_IDLE next cycle and PTR SHALL become (owner+1) mod 3.
REQ-021 Consequence of REQ-016 and REQ-020: a one-cycle ST_IDLE gap SHALL separate consecutive packets; arbitration latency is 1 cycle from ST_IDLE.
REQ-022 A single-byte packet (LAST=1 on first byte) SHALL be legal and SHALL release after its one ACK.
REQ-023 UART_ACK while UART_STB=0 SHALL be ignored.
REQ-024 PTR (2 bits) SHALL hold only 0..2; value 3 SHALL never occur.

Reset
REQ-025 On OPB_RST: state=ST_IDLE, PTR=0, stall counter=0, TIMEOUT_ERR=0, GRANT=3, BUSY=0, UART_STB=0, UART_DATA=0, REQn_ACK=0.
REQ-026 Reset asserted mid-packet SHALL abort the packet; the owner's remaining bytes SHALL be re-arbitrated as a new packet after reset.

Configuration
REQ-027 Macro MSSB_ARB_TIMEOUT_EN SHALL compile in the stall watchdog.
REQ-028 With MSSB_ARB_TIMEOUT_EN defined, a 20-bit counter SHALL count ST_XFER cycles with owner STB=0, SHALL clear on every owner ACK and in ST_IDLE, and at TIMEOUT_CYCLES SHALL force ST_IDLE, advance PTR past the owner, and set TIMEOUT_ERR.
REQ-029 A timeout coinciding with ERR_CLR SHALL leave TIMEOUT_ERR set.
REQ-030 Without MSSB_ARB_TIMEOUT_EN, no counter SHALL exist, grants SHALL never be revoked, and TIMEOUT_ERR SHALL be tied 0.

Verification
REQ-031 REQ0 sends a 3-byte packet {0x10,0x11,0x12 LAST}, UART_ACK every 10 cycles -> GRANT=0, three REQ0_ACK pulses, GRANT=3 one cycle after the third ACK, PTR=1.
REQ-032 REQ0/1/2 STB all high from reset, 2-byte packets each -> grant order 0,1,2,0, with one ST_IDLE cycle between packets.
REQ-033 REQ1 asserts STB mid-packet of REQ0 -> REQ1_ACK stays 0 until REQ0's LAST ACK, then GRANT=1.
REQ-034 (MSSB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) REQ2 drops STB after byte 1 without LAST -> release after 16 cycles, TIMEOUT_ERR=1, and it stays 1 until an ERR_CLR pulse clears it to 0.
REQ-035 OPB_RST pulsed while GRANT=1 mid-packet -> all outputs at reset values immediately, GRANT=3, and arbitration restarts from PTR=0.
